// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-channel registered multiplexer.
package mux_pkg;

    // Channel selection policy.
    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    // Width of a channel index for n channels.
    function automatic int chan_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr and wraps
// around, granting the first requesting channel it meets.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4,
    localparam int CW = chan_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] gidx,
    output logic          any
);

    // One extra bit so ptr + offset cannot overflow before the wrap correction.
    localparam logic [CW:0] N_W = (CW+1)'(N);

    // Walk the channels from ptr upward with wrap-around; the first hit wins.
    always_comb begin
        logic [CW:0] w_idx;
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        w_idx = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                w_idx = {1'b0, ptr} + (CW+1)'(k);
                if (w_idx >= N_W) begin
                    w_idx = w_idx - N_W;
                end
                if (!any && req[w_idx[CW-1:0]]) begin
                    grant[w_idx[CW-1:0]] = 1'b1;
                    gidx                 = w_idx[CW-1:0];
                    any                  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_n_rr.sv
// N-channel registered multiplexer with valid/ready on every input and on the
// output. Channel choice is either a fixed software select or round-robin.
// The output register holds the selected word and its source channel.
module mux_n_rr
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int CW   = chan_w(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [CW-1:0]      sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [CW-1:0]      out_chan,
    input  logic               out_ready
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CW-1:0]    r_out_chan;
    logic [CW-1:0]    r_ptr;

    logic             w_load_en;
    logic             w_rr;
    logic [N-1:0]     w_arb_grant;
    logic [CW-1:0]    w_arb_gidx;
    logic             w_arb_any;
    logic [N-1:0]     w_fix_grant;
    logic [N-1:0]     w_grant;
    logic [CW-1:0]    w_gidx;
    logic             w_any;
    logic [WIDTH-1:0] w_sel_data;

    // The register may be refilled when it is empty or being drained this cycle.
    assign w_load_en = !r_out_valid || out_ready;
    assign w_rr      = (mode == MODE_RR);

    rr_arbiter #(.N(N)) u_arb (
        .req   (in_valid),
        .ptr   (r_ptr),
        .en    (w_load_en && w_rr),
        .grant (w_arb_grant),
        .gidx  (w_arb_gidx),
        .any   (w_arb_any)
    );

    // Fixed mode grants only the selected channel; an out-of-range select grants nothing.
    always_comb begin
        w_fix_grant = '0;
        if (w_load_en && (int'(sel) < N) && in_valid[sel]) begin
            w_fix_grant[sel] = 1'b1;
        end
    end

    // Nothing is granted while reset is held, so no producer sees a false accept.
    assign w_grant  = !rst_n ? '0 : (w_rr ? w_arb_grant : w_fix_grant);
    assign w_gidx   = w_rr ? w_arb_gidx : sel;
    assign w_any    = |w_grant;
    assign in_ready = w_grant;

    assign w_sel_data = in_data[int'(w_gidx)*WIDTH +: WIDTH];

    // Output register and round-robin pointer; data/channel hold when nothing loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_chan  <= w_gidx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_rr && w_any) begin
                r_ptr <= (int'(w_arb_gidx) == N-1) ? '0 : w_arb_gidx + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux_n_rr.sv
// Directed scoreboard bench for mux_n_rr: the stimulus pushes the expected
// {data, chan} of every granted word, a monitor pops on each output handshake.
module tb_mux_n_rr;
    import mux_pkg::*;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int CW    = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               mode;
    logic [CW-1:0]      sel;
    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [CW-1:0]      out_chan;
    logic               out_ready;

    // Second instance with a non-power-of-two channel count to reach sel >= N.
    logic               mode5;
    logic [2:0]         sel5;
    logic [4:0]         in_valid5;
    logic [39:0]        in_data5;
    logic [4:0]         in_ready5;
    logic               out_valid5;
    logic [7:0]         out_data5;
    logic [2:0]         out_chan5;
    logic               out_ready5;

    logic [WIDTH-1:0]      dat [N];
    logic [WIDTH+CW-1:0]   exp_q [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = dat[i];
    end

    mux_n_rr #(.N(N), .WIDTH(WIDTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready)
    );

    mux_n_rr #(.N(5), .WIDTH(8)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
        .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_chan(out_chan5),
        .out_ready(out_ready5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One clock cycle: drive after the edge, check in_ready/out_valid mid-cycle,
    // and queue the word that the next edge is expected to load.
    task automatic cycle(input logic rst, input logic m, input logic [CW-1:0] s,
                         input logic [N-1:0] v, input logic r,
                         input logic [N-1:0] exp_rdy, input int exp_ov, input bit do_push);
        @(posedge clk);
        #1;
        rst_n = rst; mode = m; sel = s; in_valid = v; out_ready = r;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_ov >= 0) chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (do_push) begin
            for (int i = 0; i < N; i++) begin
                if (exp_rdy[i]) exp_q.push_back({dat[i], CW'(i)});
            end
        end
    endtask

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        logic [WIDTH+CW-1:0] e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL xfer: got chan=%0d data=%h, expected no word", out_chan, out_data);
            end else begin
                e = exp_q.pop_front();
                if ({out_data, out_chan} !== e) begin
                    bad++;
                    $display("FAIL xfer: got chan=%0d data=%h, expected chan=%0d data=%h",
                             out_chan, out_data, e[CW-1:0], e[WIDTH+CW-1:CW]);
                end else begin
                    $display("xfer chan=%0d data=%h ok", out_chan, out_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    localparam logic RR = 1'b1;
    localparam logic FX = 1'b0;

    initial begin
        for (int i = 0; i < N; i++) dat[i] = WIDTH'(8'hA0 + i);
        rst_n = 1'b0; mode = RR; sel = '0; in_valid = 4'b1111; out_ready = 1'b1;
        mode5 = FX; sel5 = 3'd0; in_valid5 = 5'b11111; out_ready5 = 1'b1;
        in_data5 = {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0};

        // Reset held for two edges with every input active.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_chan", 32'(out_chan), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        rst_n = 1'b1; in_valid = '0;

        // Round-robin, all valid: 0,1,2,3,0.
        cycle(1, RR, 0, 4'b1111, 1, 4'b0001, 0, 1);
        cycle(1, RR, 0, 4'b1111, 1, 4'b0010, 1, 1);
        cycle(1, RR, 0, 4'b1111, 1, 4'b0100, 1, 1);
        cycle(1, RR, 0, 4'b1111, 1, 4'b1000, 1, 1);
        cycle(1, RR, 0, 4'b1111, 1, 4'b0001, 1, 1);
        // Channels 1 and 3 only: alternate, pointer wraps past 3.
        cycle(1, RR, 0, 4'b1010, 1, 4'b0010, 1, 1);
        cycle(1, RR, 0, 4'b1010, 1, 4'b1000, 1, 1);
        cycle(1, RR, 0, 4'b1010, 1, 4'b0010, 1, 1);
        cycle(1, RR, 0, 4'b1010, 1, 4'b1000, 1, 1);

        // Fixed select 2, then a select pointing at an idle channel.
        cycle(1, FX, 2, 4'b1111, 1, 4'b0100, 1, 1);
        cycle(1, FX, 2, 4'b1111, 1, 4'b0100, 1, 1);
        cycle(1, FX, 2, 4'b1111, 1, 4'b0100, 1, 1);
        cycle(1, FX, 3, 4'b0111, 1, 4'b0000, 1, 1);

        // Backpressure with ch1 = 0x55 (ptr still 0 from RR).
        dat[1] = 8'h55;
        cycle(1, RR, 0, 4'b0010, 1, 4'b0010, 0, 1);
        cycle(1, RR, 0, 4'b0010, 0, 4'b0000, 1, 1);
        chk("hold_data", 32'(out_data), 32'h55);
        chk("hold_chan", 32'(out_chan), 1);
        dat[1] = 8'h66;
        cycle(1, RR, 0, 4'b0010, 0, 4'b0000, 1, 1);
        chk("hold_data", 32'(out_data), 32'h55);
        cycle(1, RR, 0, 4'b0010, 0, 4'b0000, 1, 1);
        chk("hold_data", 32'(out_data), 32'h55);
        // Drain and refill in the same cycle.
        cycle(1, RR, 0, 4'b0010, 1, 4'b0010, 1, 1);

        // Mode switch: bring ptr to 3, fixed sel=0, then RR resumes at 3.
        cycle(1, RR, 0, 4'b0100, 1, 4'b0100, 1, 1);
        cycle(1, FX, 0, 4'b1111, 1, 4'b0001, 1, 1);
        cycle(1, RR, 0, 4'b1111, 1, 4'b1000, 1, 1);

        // Mid-operation reset: load a word (ptr -> 2), stall, then reset it away.
        cycle(1, RR, 0, 4'b0010, 1, 4'b0010, 1, 0);
        cycle(1, RR, 0, 4'b0000, 0, 4'b0000, 1, 0);
        cycle(0, RR, 0, 4'b1111, 0, 4'b0000, 1, 0);
        cycle(1, RR, 0, 4'b0000, 1, 4'b0000, 0, 0);
        chk("post_rst_data", 32'(out_data), 0);
        cycle(1, RR, 0, 4'b1111, 1, 4'b0001, 0, 1);
        cycle(1, RR, 0, 4'b0000, 1, 4'b0000, 1, 0);

        // Five-channel instance: sel=4 is valid, sel=5 and 7 are out of range.
        @(posedge clk); #1; sel5 = 3'd4;
        @(negedge clk);
        chk("n5_ready_sel4", 32'(in_ready5), 32'b10000);
        @(posedge clk); #1; sel5 = 3'd5;
        @(negedge clk);
        chk("n5_ready_sel5", 32'(in_ready5), 0);
        chk("n5_out_chan", 32'(out_chan5), 4);
        chk("n5_out_data", 32'(out_data5), 32'hC4);
        @(posedge clk); #1; sel5 = 3'd7;
        @(negedge clk);
        chk("n5_ready_sel7", 32'(in_ready5), 0);
        chk("n5_out_valid", 32'(out_valid5), 0);

        // Let any queued word drain within a bounded number of cycles.
        in_valid = '0; out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_n_rr.md
# mux_n_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input and on the output. It is the successor to the 2:1 combinational mux. Channel selection is either fixed (software-driven `sel`) or round-robin arbitration among valid inputs. It sits between multiple producers and a single shared consumer, and registers the selected word together with its source channel number.

## Interface
- `N`, 4, number of input channels (≥2)
- `WIDTH`, 8, data width per channel
- `CW`, `$clog2(N)`, channel index width (derived, not overridden)
---
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `mode`  in  1  0 = fixed select, 1 = round-robin
- `sel`  in  CW  granted channel in fixed mode
- `in_valid`  in  N  per-channel valid
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_ready`  out  N  per-channel ready; one-hot or zero
- `out_valid`  out  1  output register holds a word
- `out_data`  out  WIDTH  registered selected word
- `out_chan`  out  CW  source channel of `out_data`
- `out_ready`  in  1  consumer accepts

## Operation
- `load_en = !out_valid || out_ready`. Arbitration happens only when `load_en` is high.
- Fixed mode:
  - `grant[sel] = in_valid[sel] && load_en`.
  - Other channels are never granted.
  - `sel ≥ N` means no grant.
- Round-robin mode:
  - Search starts at pointer `ptr` and proceeds `ptr, ptr+1, …, N-1, 0, …` (wrap-around).
  - The first valid channel is granted.
  - After a grant to channel g, `ptr ← (g+1) mod N`.
  - With no grant, `ptr` is unchanged.
- `in_ready = grant`. This is combinational from `in_valid`, `mode`, `sel`, `ptr`, `out_valid` and `out_ready`. An input transfer occurs when `in_valid[i] && in_ready[i]`.
- On a transfer: `out_data ← in_data[g]`, `out_chan ← g`, `out_valid ← 1`.
- With `out_ready` high and no grant: `out_valid ← 0`; `out_data`/`out_chan` hold their values.
- With `out_valid` high and `out_ready` low: all outputs hold and `in_ready = 0`.
- A `mode` change takes effect on the next arbitration. It does not disturb the word held in the output register. `ptr` is kept across mode changes and is not updated in fixed mode.

## Timing
- Reset (`rst_n` low at a clk edge):
  - `out_valid=0`, `out_data=0`, `out_chan=0`, `ptr=0`.
  - `in_ready=0` while `rst_n` is low.
  - A reset asserted mid-transfer discards the held word.
- Latency: an input accepted at edge k appears on `out_*` after edge k (1 cycle).
- Throughput: 1 word/cycle when `out_ready` is held high.
- Simultaneous events: a drain and a load in the same cycle replace the word with no bubble.
- A valid input that is not granted must hold its data. The block never drops or duplicates a word.
- Round-robin fairness: a continuously valid channel is granted within N arbitration cycles.

## Structure
- Package `mux_pkg`:
  - `mux_mode_e` with values `MODE_FIXED=1'b0` and `MODE_RR=1'b1`.
  - Function `chan_w(n)` returning `$clog2(n)`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]`, `ptr[CW]`, `en`.
  - Outputs: one-hot `grant[N]`, `gidx[CW]`, `any`.
  - Purely combinational.
  - The top level owns `ptr`, the fixed/RR mux of the grant, and the output register.

## Test plan
- Reset: drive all inputs active with `rst_n=0` for 2 cycles → `out_valid=0`, `out_data=0`, `in_ready=0`. Release → first grant goes to ch0 (`ptr=0`).
- Fixed mode, `sel=2`, `in_valid=4'b1111`, `in_data` ch i = 0xA0+i, `out_ready=1` → `in_ready=4'b0100` every cycle; `out_data=0xA2`, `out_chan=2` one cycle later. `sel=5` (N=8, ch5 invalid) → `out_valid` drops.
- Round-robin, all 4 channels valid, `out_ready=1` → `out_chan` sequence 0,1,2,3,0,… Then `in_valid=4'b1010` → alternates 1,3, with `ptr` wrap verified.
- Backpressure: `out_ready=0` for 3 cycles with ch1 holding 0x55 → `out_data` stays 0x55 and `in_ready=0`. Raise `out_ready` → the next word loads in the same cycle, with no bubble.
- Mode switch: in RR with `ptr=3`, switch to fixed `sel=0` → ch0 granted next. Switch back to RR → search resumes at 3.
- Mid-operation reset: `out_valid=1` and `ptr=2`, pulse `rst_n` low for 1 cycle → `out_valid=0`, `ptr=0`. No stale word is delivered afterwards.
